gshare_predictor: RTL and testbench

- Global-history direction predictor. Supplies the global prediction to the fetch-stage tournament chooser.
- Indexes a pattern history table (PHT) of 2-bit saturating counters with PC XOR global history register (GHR).
- Emits a direction and the PHT index used. The index travels down the pipeline with the instruction.
- Trains counters and shifts the GHR when a conditional branch resolves in EX/MEM. The update qualifier is the same one the chooser uses.

---
 rtl/gshare_predictor.sv | 147 ++++++++++++++
 tb/tb_gshare_predictor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Global-history direction predictor feeding the fetch-stage tournament
// chooser. A table of 2-bit saturating counters (PHT) is indexed by the
// fetch PC XOR the global history register (GHR). The predicted direction
// and the index used are emitted. The index travels with the instruction so
// that training at EX/MEM hits the same counter that made the prediction.
//
// Training happens when a conditional branch resolves and the pipeline is
// not stalled. At that point the addressed counter steps one position
// toward the outcome, and the outcome is shifted into the GHR LSB. The
// history is non-speculative.
//
// Ports:
//   clk            in   1          clock
//   rst            in   1          synchronous active-high reset
//   stall          in   1          pipeline stall, blocks all state updates
//   if_pc          in   32         PC of the instruction being fetched
//   gl_br_dir      out  1          global prediction, 1 = taken
//   gl_idx         out  PHT_IDX_W  PHT index used for gl_br_dir
//   ex_mem_opcode  in   7          opcode of the resolving instruction
//   ex_mem_br_en   in   1          resolved branch outcome, 1 = taken
//   ex_mem_gl_idx  in   PHT_IDX_W  gl_idx carried with the resolving branch
//   ghr_out        out  GHR_W      registered GHR, for debug/perf counters
//
// Configuration macro:
//   GSHARE_FWD_EN  When defined, the lookup sees this cycle's training
//                  immediately. Both the shifted GHR and the post-update
//                  counter are forwarded. When undefined, the lookup reads
//                  only registered state.
// -----------------------------------------------------------------------------
module gshare_predictor #(
    parameter int          PHT_IDX_W = 8,
    parameter int          GHR_W     = 8,
    parameter logic [1:0]  CTR_RST   = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [31:0]          if_pc,
    output logic                 gl_br_dir,
    output logic [PHT_IDX_W-1:0] gl_idx,
    input  logic [6:0]           ex_mem_opcode,
    input  logic                 ex_mem_br_en,
    input  logic [PHT_IDX_W-1:0] ex_mem_gl_idx,
    output logic [GHR_W-1:0]     ghr_out
);

    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam int         PHT_DEPTH = 1 << PHT_IDX_W;

    // One step of the counter state machine SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b10 : 2'b00;
            2'b10:   nxt = taken ? 2'b11 : 2'b01;
            2'b11:   nxt = taken ? 2'b11 : 2'b10;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

    logic [1:0]           pht_r [PHT_DEPTH];
    logic [GHR_W-1:0]     ghr_r;

    logic                 upd_s;
    logic [1:0]           ctr_next_s;
    logic [GHR_W-1:0]     ghr_next_s;
    logic [GHR_W:0]       ghr_cat_s;
    logic [PHT_IDX_W-1:0] pc_idx_s;
    logic [GHR_W-1:0]     ghr_term_s;
    logic [PHT_IDX_W-1:0] idx_s;
    logic [1:0]           ctr_rd_s;

    // PC bits outside the index field and the byte offset are intentionally ignored (aliasing allowed).
    logic                 unused_pc_bits_s;
    assign unused_pc_bits_s = ^{if_pc[31:PHT_IDX_W+2], if_pc[1:0]};

    // Training qualifier and next-state values for the addressed counter and the GHR.
    always_comb begin
        upd_s      = 1'b0;
        ctr_next_s = 2'b00;
        ghr_cat_s  = '0;
        ghr_next_s = '0;
        if (!stall && (ex_mem_opcode == OP_BR)) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
        ctr_next_s = ctr_step(pht_r[ex_mem_gl_idx], ex_mem_br_en);
        // Newest outcome enters at the LSB; the oldest bit falls off the top.
        ghr_cat_s  = {ghr_r, ex_mem_br_en};
        ghr_next_s = ghr_cat_s[GHR_W-1:0];
    end

    // Lookup: PC index field XOR zero-extended history, then read the counter MSB.
    always_comb begin
        pc_idx_s   = if_pc[PHT_IDX_W+1:2];
        ghr_term_s = ghr_r;
        idx_s      = '0;
        ctr_rd_s   = 2'b00;
`ifdef GSHARE_FWD_EN
        if (upd_s) begin
            ghr_term_s = ghr_next_s;
        end else begin
            ghr_term_s = ghr_r;
        end
        idx_s = pc_idx_s ^ PHT_IDX_W'(ghr_term_s);
        if (upd_s && (ex_mem_gl_idx == idx_s)) begin
            ctr_rd_s = ctr_next_s;
        end else begin
            ctr_rd_s = pht_r[idx_s];
        end
`else
        idx_s    = pc_idx_s ^ PHT_IDX_W'(ghr_term_s);
        ctr_rd_s = pht_r[idx_s];
`endif
    end

    assign gl_idx    = idx_s;
    assign gl_br_dir = ctr_rd_s[1];
    assign ghr_out   = ghr_r;

    // PHT storage: reset loads every counter, otherwise train the carried index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_r[i] <= CTR_RST;
            end
        end else if (upd_s) begin
            pht_r[ex_mem_gl_idx] <= ctr_next_s;
        end
    end

    // Global history register: committed only at branch resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (upd_s) begin
            ghr_r <= ghr_next_s;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
//
// Self-checking bench for gshare_predictor at default parameters. A
// reference model holds the PHT as an integer array and the history as an
// integer. On every cycle the model computes the expected gl_idx, gl_br_dir
// and ghr_out. Directed steps pin the model with hand-computed literals.
// A long randomized run then exercises stalls, mixed opcodes, index
// collisions and occasional resets.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        gl_br_dir;
    logic [7:0]  gl_idx;
    logic [6:0]  ex_mem_opcode;
    logic        ex_mem_br_en;
    logic [7:0]  ex_mem_gl_idx;
    logic [7:0]  ghr_out;

    int vectors;
    int miscompares;

    // Reference model state.
    int pht_m [256];
    int ghr_m;

    gshare_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_pc         (if_pc),
        .gl_br_dir     (gl_br_dir),
        .gl_idx        (gl_idx),
        .ex_mem_opcode (ex_mem_opcode),
        .ex_mem_br_en  (ex_mem_br_en),
        .ex_mem_gl_idx (ex_mem_gl_idx),
        .ghr_out       (ghr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int c, input bit taken);
        if (taken) return (c >= 3) ? 3 : c + 1;
        else       return (c <= 0) ? 0 : c - 1;
    endfunction

    // Drive one cycle of inputs, check the lookup outputs, then advance the model.
    task automatic apply(input bit r, input bit s, input logic [31:0] pc,
                         input logic [6:0] op, input bit br, input logic [7:0] xidx);
        int  pcidx, ghr_t, idx, ctr, e_dir;
        bit  upd;
        @(negedge clk);
        rst = r; stall = s; if_pc = pc; ex_mem_opcode = op;
        ex_mem_br_en = br; ex_mem_gl_idx = xidx;
        #1;
        upd   = !s && (op == OP_BR);
        pcidx = (pc >> 2) % 256;
        ghr_t = ghr_m;
`ifdef GSHARE_FWD_EN
        if (upd) ghr_t = ((ghr_m * 2) + br) % 256;
`endif
        idx = pcidx ^ ghr_t;
        ctr = pht_m[idx];
`ifdef GSHARE_FWD_EN
        if (upd && (int'(xidx) == idx)) ctr = sat(pht_m[xidx], br);
`endif
        e_dir = (ctr >= 2) ? 1 : 0;
        cmp("gl_idx", int'(gl_idx), idx);
        cmp("gl_br_dir", int'(gl_br_dir), e_dir);
        cmp("ghr_out", int'(ghr_out), ghr_m);
        // State change that the coming posedge performs.
        if (r) begin
            for (int i = 0; i < 256; i++) pht_m[i] = 1;
            ghr_m = 0;
        end else if (upd) begin
            pht_m[xidx] = sat(pht_m[xidx], br);
            ghr_m = ((ghr_m * 2) + br) % 256;
        end
    endtask

    initial begin
        int pidx, xi, pc_idx_now;
        logic [6:0] op;
        logic [31:0] pc;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) pht_m[i] = 1;
        ghr_m = 0;
        rst = 1'b1; stall = 1'b0; if_pc = 32'h0; ex_mem_opcode = OP_ADD;
        ex_mem_br_en = 1'b0; ex_mem_gl_idx = 8'h00;

        apply(1'b1, 1'b0, 32'h0, OP_ADD, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 32'h0, OP_ADD, 1'b0, 8'h00);

        // Reset state lookup.
        apply(1'b0, 1'b0, 32'h0000_0100, OP_ADD, 1'b0, 8'h00);
        cmp("rst_gl_idx", int'(gl_idx), 32'h40);
        cmp("rst_dir", int'(gl_br_dir), 0);
        cmp("rst_ghr", int'(ghr_out), 0);

        // Two taken commits at 0x40.
        apply(1'b0, 1'b0, 32'h0000_0100, OP_BR, 1'b1, 8'h40);
        apply(1'b0, 1'b0, 32'h0000_0100, OP_BR, 1'b1, 8'h40);
        apply(1'b0, 1'b0, 32'h0000_0100, OP_ADD, 1'b0, 8'h00);
        cmp("two_taken_ghr", int'(ghr_out), 3);
        cmp("two_taken_idx", int'(gl_idx), 32'h43);
        cmp("two_taken_dir43", int'(gl_br_dir), 0);
        // Index 0x40 with GHR=0x03 needs PC index 0x43.
        apply(1'b0, 1'b0, 32'h0000_010C, OP_ADD, 1'b0, 8'h00);
        cmp("pht40_strong", int'(gl_br_dir), 1);

        // Counter path at 0x10: four taken then three not taken.
        for (int k = 0; k < 4; k++) apply(1'b0, 1'b0, 32'h0, OP_BR, 1'b1, 8'h10);
        // GHR = 0x3F, index 0x10 needs PC index 0x2F.
        apply(1'b0, 1'b0, 32'h0000_00BC, OP_ADD, 1'b0, 8'h00);
        cmp("pht10_sat_dir", int'(gl_br_dir), 1);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 32'h0, OP_BR, 1'b0, 8'h10);
        // GHR = 0xF8, index 0x10 needs PC index 0xE8.
        apply(1'b0, 1'b0, 32'h0000_03A0, OP_ADD, 1'b0, 8'h00);
        cmp("pht10_ghr", int'(ghr_out), 32'hF8);
        cmp("pht10_end_dir", int'(gl_br_dir), 0);

        // Stall and non-branch opcodes leave state alone.
        apply(1'b0, 1'b1, 32'h0000_03A0, OP_BR, 1'b1, 8'h10);
        apply(1'b0, 1'b0, 32'h0000_03A0, OP_JAL, 1'b1, 8'h10);
        apply(1'b0, 1'b0, 32'h0000_03A0, OP_ADD, 1'b0, 8'h00);
        cmp("blocked_ghr", int'(ghr_out), 32'hF8);
        cmp("blocked_dir", int'(gl_br_dir), 0);

        // Same-cycle lookup and update at 0x05 from a fresh reset.
        apply(1'b1, 1'b0, 32'h0, OP_ADD, 1'b0, 8'h00);
`ifdef GSHARE_FWD_EN
        // Shifted GHR = 1, so PC index 0x04 lands on 0x05.
        apply(1'b0, 1'b0, 32'h0000_0010, OP_BR, 1'b1, 8'h05);
        cmp("same_cycle_fwd_idx", int'(gl_idx), 5);
        cmp("same_cycle_fwd_dir", int'(gl_br_dir), 1);
`else
        apply(1'b0, 1'b0, 32'h0000_0014, OP_BR, 1'b1, 8'h05);
        cmp("same_cycle_idx", int'(gl_idx), 5);
        cmp("same_cycle_dir", int'(gl_br_dir), 0);
`endif
        apply(1'b0, 1'b0, 32'h0000_0010, OP_ADD, 1'b0, 8'h00);
        cmp("next_cycle_idx", int'(gl_idx), 5);
        cmp("next_cycle_dir", int'(gl_br_dir), 1);

        // Reset coincident with a taken update: the update is lost.
        apply(1'b1, 1'b0, 32'h0, OP_BR, 1'b1, 8'h05);
        apply(1'b0, 1'b0, 32'h0000_0014, OP_ADD, 1'b0, 8'h00);
        cmp("rst_win_ghr", int'(ghr_out), 0);
        cmp("rst_win_dir", int'(gl_br_dir), 0);
        // Reset during stall still applies.
        apply(1'b0, 1'b0, 32'h0, OP_BR, 1'b1, 8'h07);
        apply(1'b1, 1'b1, 32'h0, OP_ADD, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 32'h0, OP_ADD, 1'b0, 8'h00);
        cmp("rst_stall_ghr", int'(ghr_out), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            pidx = $urandom_range(0, 31);
            pc   = ($urandom & 32'hFFFF_FC03) | (32'(pidx) << 2);
            case ($urandom_range(0, 9))
                0:       op = OP_JAL;
                1:       op = 7'($urandom);
                default: op = OP_BR;
            endcase
            pc_idx_now = ((pc >> 2) % 256) ^ ghr_m;
            xi = ($urandom_range(0, 1) == 1) ? pc_idx_now : $urandom_range(0, 31);
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), pc, op,
                  1'($urandom), 8'(xi));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
